// File: rtl/paint_pkg.sv
// Shared framebuffer geometry, colour codes and brush FSM states for the paint pipeline.
// Constants only: no latency, no flow control.
package paint_pkg;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int ADDR_W  = 15;
    localparam int COLOR_W = 3;

    localparam logic [COLOR_W-1:0] BLACK  = 3'd0;
    localparam logic [COLOR_W-1:0] RED    = 3'd1;
    localparam logic [COLOR_W-1:0] ORANGE = 3'd2;
    localparam logic [COLOR_W-1:0] YELLOW = 3'd3;
    localparam logic [COLOR_W-1:0] GREEN  = 3'd4;
    localparam logic [COLOR_W-1:0] BLUE   = 3'd5;
    localparam logic [COLOR_W-1:0] PURPLE = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        DONE  = 2'd2
    } brush_state_t;

endpackage

// File: rtl/brush_scan.sv
// Raster dx/dy walker over [-r..r]^2, dx fastest; load presets (-r,-r).
// Moves one cell per adv pulse; holds position while adv is low.
module brush_scan (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [1:0] load_r,
    input  logic       adv,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       last
);

    logic [3:0] dx_q, dx_d;
    logic [3:0] dy_q, dy_d;
    logic [1:0] r_q, r_d;
    logic [3:0] r_ext;

    // dx/dy are 4-bit two's complement, covering -3..3
    assign r_ext = {2'b00, r_q};

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        r_d  = r_q;
        if (load) begin
            r_d  = load_r;
            dx_d = 4'd0 - {2'b00, load_r};
            dy_d = 4'd0 - {2'b00, load_r};
        end else if (adv) begin
            if (dx_q == r_ext) begin
                dx_d = 4'd0 - r_ext;
                dy_d = dy_q + 4'd1;
            end else begin
                dx_d = dx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dx_q <= 4'd0;
            dy_q <= 4'd0;
            r_q  <= 2'd0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            r_q  <= r_d;
        end
    end

    assign dx   = dx_q;
    assign dy   = dy_q;
    assign last = (dx_q == r_ext) && (dy_q == r_ext);

endmodule

// File: rtl/brush_stamper.sv
// Stamps a (2r+1)^2 brush into the 160x120 framebuffer, one pixel per fb_we&&fb_ready cycle.
// Write appears the cycle after trigger; fb_addr/fb_data hold while fb_ready is low.
// BRUSH_ROUND_EN: skip cells outside radius r (same cycle count, fewer writes).
module brush_stamper
    import paint_pkg::*;
#(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int SCALE_SHIFT = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [X_W-1:0]     x_pos,
    input  logic [Y_W-1:0]     y_pos,
    input  logic [COLOR_W-1:0] color,
    input  logic               tool_on,
    input  logic               size_sel,
    input  logic               fb_ready,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               busy,
    output logic [1:0]         brush_size
);

    brush_state_t state_q, state_d;

    logic [1:0]         brush_size_q, brush_size_d;
    logic               size_sel_q, size_sel_d;
    logic               last_valid_q, last_valid_d;
    logic [X_W-1:0]     last_cx_q, last_cx_d, cap_cx_q, cap_cx_d;
    logic [Y_W-1:0]     last_cy_q, last_cy_d, cap_cy_q, cap_cy_d;
    logic [COLOR_W-1:0] last_col_q, last_col_d, cap_col_q, cap_col_d;
    logic [1:0]         last_r_q, last_r_d, cap_r_q, cap_r_d;

    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           trigger;
    logic           scan_load;
    logic           scan_adv;
    logic           scan_last;
    logic [3:0]     dx, dy;
    logic [11:0]    px, py;
    logic           in_fb;
    logic           cell_ok;
    logic [ADDR_W-1:0] cell_addr;

    assign cx = x_pos >> SCALE_SHIFT;
    assign cy = y_pos >> SCALE_SHIFT;

    brush_scan u_scan (
        .clk    (clk),
        .clr    (clr),
        .load   (scan_load),
        .load_r (brush_size_q),
        .adv    (scan_adv),
        .dx     (dx),
        .dy     (dy),
        .last   (scan_last)
    );

    // 12-bit two's complement sum: negative cells show up as bit 11 set
    assign px = 12'(cap_cx_q) + {{8{dx[3]}}, dx};
    assign py = 12'(cap_cy_q) + {{8{dy[3]}}, dy};
    assign in_fb = !px[11] && !py[11] && (px < 12'(FB_W)) && (py < 12'(FB_H));
    assign cell_addr = ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);

`ifdef BRUSH_ROUND_EN
    logic [3:0] adx, ady;
    logic [4:0] dist2, rad2;
    assign adx     = dx[3] ? (4'd0 - dx) : dx;
    assign ady     = dy[3] ? (4'd0 - dy) : dy;
    assign dist2   = 5'(adx * adx) + 5'(ady * ady);
    assign rad2    = 5'({2'b00, cap_r_q} * {2'b00, cap_r_q});
    assign cell_ok = in_fb && (dist2 <= rad2);
`else
    assign cell_ok = in_fb;
`endif

    always_comb begin
        state_d      = state_q;
        brush_size_d = brush_size_q;
        size_sel_d   = size_sel;
        last_valid_d = last_valid_q;
        last_cx_d    = last_cx_q;
        last_cy_d    = last_cy_q;
        last_col_d   = last_col_q;
        last_r_d     = last_r_q;
        cap_cx_d     = cap_cx_q;
        cap_cy_d     = cap_cy_q;
        cap_col_d    = cap_col_q;
        cap_r_d      = cap_r_q;
        scan_load    = 1'b0;
        scan_adv     = 1'b0;
        fb_we        = 1'b0;
        fb_addr      = '0;
        fb_data      = '0;

        if (size_sel && !size_sel_q) begin
            brush_size_d = brush_size_q + 2'd1;
        end

        trigger = (state_q == IDLE) && tool_on &&
                  (!last_valid_q || (cx != last_cx_q) || (cy != last_cy_q) ||
                   (color != last_col_q) || (brush_size_q != last_r_q));

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    cap_cx_d  = cx;
                    cap_cy_d  = cy;
                    cap_col_d = color;
                    cap_r_d   = brush_size_q;
                    scan_load = 1'b1;
                    state_d   = STAMP;
                end
            end
            STAMP: begin
                fb_we    = cell_ok;
                fb_addr  = cell_ok ? cell_addr : '0;
                fb_data  = cell_ok ? cap_col_q : '0;
                scan_adv = !cell_ok || fb_ready;
                if (scan_adv && scan_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_cx_d    = cap_cx_q;
                last_cy_d    = cap_cy_q;
                last_col_d   = cap_col_q;
                last_r_d     = cap_r_q;
                last_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Painting disabled forgets the last stamp so re-enabling always paints once
        if (!tool_on) begin
            last_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            brush_size_q <= 2'd0;
            size_sel_q   <= 1'b0;
            last_valid_q <= 1'b0;
            last_cx_q    <= '0;
            last_cy_q    <= '0;
            last_col_q   <= '0;
            last_r_q     <= 2'd0;
            cap_cx_q     <= '0;
            cap_cy_q     <= '0;
            cap_col_q    <= '0;
            cap_r_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            brush_size_q <= brush_size_d;
            size_sel_q   <= size_sel_d;
            last_valid_q <= last_valid_d;
            last_cx_q    <= last_cx_d;
            last_cy_q    <= last_cy_d;
            last_col_q   <= last_col_d;
            last_r_q     <= last_r_d;
            cap_cx_q     <= cap_cx_d;
            cap_cy_q     <= cap_cy_d;
            cap_col_q    <= cap_col_d;
            cap_r_q      <= cap_r_d;
        end
    end

    assign busy       = (state_q == STAMP);
    assign brush_size = brush_size_q;

endmodule

// File: tb/tb_brush_stamper.sv
// Directed + randomized bench for brush_stamper with a footprint-list reference model.
module tb_brush_stamper;

    logic        clk = 1'b0;
    logic        clr;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [2:0]  color;
    logic        tool_on;
    logic        size_sel;
    logic        fb_ready;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;
    logic [1:0]  brush_size;

    brush_stamper dut (
        .clk        (clk),
        .clr        (clr),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .color      (color),
        .tool_on    (tool_on),
        .size_sel   (size_sel),
        .fb_ready   (fb_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .busy       (busy),
        .brush_size (brush_size)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [17:0] wq[$];
    logic [17:0] exp_q[$];
    int cyc = 0, t0 = 0, first_wr = -1, busy_cnt = 0, stall_cnt = 0;
    bit hold_pend = 0;
    logic [14:0] h_addr;
    logic [2:0]  h_data;

    // reference model state: what the last committed stamp was
    bit m_valid = 0;
    int m_cx, m_cy, m_col, m_r;
    int m_size = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (hold_pend && clr) begin
            chk("hold_we", {31'd0, fb_we}, 32'd1);
            chk("hold_addr", {17'd0, fb_addr}, {17'd0, h_addr});
            chk("hold_data", {29'd0, fb_data}, {29'd0, h_data});
        end
        hold_pend = clr && fb_we && !fb_ready;
        h_addr    = fb_addr;
        h_data    = fb_data;
        if (busy) busy_cnt++;
        if (fb_we && !fb_ready) stall_cnt++;
        if (fb_we && fb_ready) begin
            if (first_wr < 0) first_wr = cyc;
            wq.push_back({fb_addr, fb_data});
        end
    end

    task automatic build(input int cx, input int cy, input int col, input int r);
        exp_q.delete();
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                int px, py;
                bit keep;
                px = cx + dx;
                py = cy + dy;
                keep = (px >= 0) && (py >= 0) && (px < 160) && (py < 120);
`ifdef BRUSH_ROUND_EN
                if (dx * dx + dy * dy > r * r) keep = 0;
`endif
                if (keep) exp_q.push_back({15'(py * 160 + px), 3'(col)});
            end
        end
    endtask

    task automatic apply(input int x, input int y, input int c, input bit t);
        @(posedge clk); #1;
        x_pos   = 10'(x);
        y_pos   = 10'(y);
        color   = 3'(c);
        tool_on = t;
        exp_q.delete();
        if (!t) begin
            m_valid = 0;
        end else if (!m_valid || (x / 4 != m_cx) || (y / 4 != m_cy) || (c != m_col) || (m_size != m_r)) begin
            build(x / 4, y / 4, c, m_size);
            m_valid = 1;
            m_cx = x / 4; m_cy = y / 4; m_col = c; m_r = m_size;
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low on iterations 2..4
    task automatic settle(input int ncyc, input int mode, input int drop_at);
        wq.delete();
        t0 = cyc; first_wr = -1; busy_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            case (mode)
                1: fb_ready = ($urandom_range(0, 3) != 0);
                2: fb_ready = !(i >= 2 && i <= 4);
                default: fb_ready = 1'b1;
            endcase
            if (i == drop_at) tool_on = 1'b0;
            @(posedge clk); #1;
        end
        fb_ready = 1'b1;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            chk({tag, "_write"}, {14'd0, wq[i]}, {14'd0, exp_q[i]});
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_size();
        @(posedge clk); #1 size_sel = 1'b1;
        @(posedge clk); #1 size_sel = 1'b0;
        m_size = (m_size + 1) % 4;
    endtask

    initial begin
        int lx, ly, lc;
        clr = 1'b0; x_pos = '0; y_pos = '0; color = '0;
        tool_on = 1'b0; size_sel = 1'b0; fb_ready = 1'b1;
        #2;
        chk("rst_we",   {31'd0, fb_we}, 32'd0);
        chk("rst_addr", {17'd0, fb_addr}, 32'd0);
        chk("rst_data", {29'd0, fb_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_size", {30'd0, brush_size}, 32'd0);
        #10 clr = 1'b1;

        // single pixel stamp
        apply(40, 20, 2, 1);
        settle(70, 0, -1);
        compare("single");
        chk("single_latency", first_wr - t0, 2);
        if (wq.size() == 1) chk("single_addr", {17'd0, wq[0][17:3]}, 810);
        exp_q.delete();
        settle(70, 0, -1);
        compare("static");

        // radius 2 at (100,50)
        apply(400, 200, 2, 0);
        settle(4, 0, -1);
        compare("off");
        pulse_size(); pulse_size();
        chk("size2", {30'd0, brush_size}, m_size);
        apply(400, 200, 2, 1);
        settle(70, 0, -1);
        compare("large");
        chk("large_busy", busy_cnt, 25);
`ifndef BRUSH_ROUND_EN
        if (wq.size() == 25) begin
            chk("large_first", {17'd0, wq[0][17:3]}, 7778);
            chk("large_last", {17'd0, wq[24][17:3]}, 8422);
        end
`endif

        // corner clip, r=1
        apply(0, 0, 3, 0);
        settle(4, 0, -1);
        pulse_size(); pulse_size(); pulse_size();
        chk("size_wrap", {30'd0, brush_size}, m_size);
        apply(0, 0, 3, 1);
        settle(70, 0, -1);
        compare("corner");
        chk("corner_busy", busy_cnt, 9);
`ifndef BRUSH_ROUND_EN
        if (wq.size() == 4) chk("corner_last", {17'd0, wq[3][17:3]}, 161);
`endif

        // backpressure on the second write
        apply(200, 100, 4, 1);
        settle(70, 2, -1);
        compare("bp");
        chk("bp_stalls", stall_cnt, 3);
        chk("bp_busy", busy_cnt, 12);

        // randomized stamps with random backpressure
        lx = 200; ly = 100; lc = 4;
        for (int k = 0; k < 12; k++) begin
            int x, y, c;
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) begin
                apply(x, y, c, 0);
                settle(4, 0, -1);
                compare("rnd_off");
                repeat ($urandom_range(1, 3)) pulse_size();
                chk("rnd_size", {30'd0, brush_size}, m_size);
            end
            if ($urandom_range(0, 3) == 0) begin
                x = lx; y = ly; c = lc;
            end
            apply(x, y, c, 1);
            settle(250, 1, -1);
            compare("rnd");
            lx = x; ly = y; lc = c;
        end

        // tool_on falling mid-stamp still finishes the footprint
        apply(300, 300, 5, 0);
        settle(4, 0, -1);
        while (m_size != 2) pulse_size();
        apply(300, 300, 5, 1);
        settle(70, 0, 3);
        compare("drop");
        m_valid = 0;
        apply(300, 300, 5, 1);
        settle(70, 0, -1);
        compare("reraise");
        apply(300, 300, 5, 1);
        settle(70, 0, -1);
        compare("reraise_static");

        // moving cursor with painting off
        for (int k = 0; k < 4; k++) begin
            apply($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7), 0);
            settle(10, 0, -1);
            compare("gated");
        end

        // asynchronous reset in the middle of an r=3 stamp
        while (m_size != 3) pulse_size();
        apply(320, 240, 1, 1);
        settle(6, 0, -1);
        #2;
        clr = 1'b0;
        tool_on = 1'b0;
        #1;
        chk("mid_rst_we",   {31'd0, fb_we}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_size", {30'd0, brush_size}, 32'd0);
        chk("mid_rst_addr", {17'd0, fb_addr}, 32'd0);
        m_size = 0;
        m_valid = 0;
        @(posedge clk); #1 clr = 1'b1;
        exp_q.delete();
        settle(70, 0, -1);
        compare("post_rst");
        apply(320, 240, 1, 1);
        settle(70, 0, -1);
        compare("post_rst_stamp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
